reg_dump: RTL and testbench

Debug readout engine for the single-cycle RISC-V core's register file. It owns one register-file read port. On a start pulse it walks every register address in ascending order. Each register's value is streamed out, with its address, over a valid/ready handshake to a debug or trace consumer. It only reads the register file and never writes it.

---
 rtl/reg_dump.sv | 118 +++++++++++
 tb/tb_reg_dump.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/reg_dump.sv
// Register-file readout engine: walks every register address and streams (addr, data) beats over valid/ready.
// Optional build macro REGDUMP_SKIP_ZERO_EN starts the walk at x0+1 since x0 is hardwired zero.
module reg_dump #(
  parameter int ADDRSIZE = 5,
  parameter int WORDSIZE = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [ADDRSIZE-1:0] rfReadReg,
  input  logic [WORDSIZE-1:0] rfReadData,
  output logic                outValid,
  input  logic                outReady,
  output logic [ADDRSIZE-1:0] outAddr,
  output logic [WORDSIZE-1:0] outData
);

`ifdef REGDUMP_SKIP_ZERO_EN
  localparam logic [ADDRSIZE-1:0] FIRST_IDX = ADDRSIZE'(1);
`else
  localparam logic [ADDRSIZE-1:0] FIRST_IDX = '0;
`endif
  localparam logic [ADDRSIZE-1:0] LAST_IDX = '1;
  localparam logic [ADDRSIZE-1:0] ONE      = ADDRSIZE'(1);

  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDRSIZE-1:0]   idx_q, idx_d;
  logic [ADDRSIZE-1:0]   rd_reg_q, rd_reg_d;
  logic [ADDRSIZE-1:0]   out_addr_q, out_addr_d;
  logic [WORDSIZE-1:0]   out_data_q, out_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rd_reg_d   = rd_reg_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d    = FIRST_IDX;
          rd_reg_d = FIRST_IDX;
          busy_d   = 1'b1;
          state_d  = READ;
        end
      end
      READ: begin
        // rfReadData is combinational off rd_reg_q, so this edge is the snapshot point.
        out_data_d = rfReadData;
        out_addr_d = idx_q;
        valid_d    = 1'b1;
        state_d    = HOLD;
      end
      HOLD: begin
        if (outReady) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d    = idx_q + ONE;
            rd_reg_d = idx_q + ONE;
            state_d  = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rd_reg_q   <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_reg_q   <= rd_reg_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rfReadReg = rd_reg_q;
  assign outValid  = valid_q;
  assign outAddr   = out_addr_q;
  assign outData   = out_data_q;

endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: behavioural register file plus a snapshot model of what each dump beat must carry.
module tb_reg_dump;
  localparam int A    = 5;
  localparam int W    = 32;
  localparam int NREG = 1 << A;
`ifdef REGDUMP_SKIP_ZERO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NB = NREG - FIRST;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         out_ready = 1'b0;
  logic         busy, done, out_valid;
  logic [A-1:0] rd_reg, out_addr;
  logic [W-1:0] rd_data, out_data;
  logic [W-1:0] rf   [NREG];
  logic [W-1:0] snap [NREG];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;
  assign rd_data = rf[rd_reg];

  reg_dump #(.ADDRSIZE(A), .WORDSIZE(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .rfReadReg  (rd_reg),
    .rfReadData (rd_data),
    .outValid   (out_valid),
    .outReady   (out_ready),
    .outAddr    (out_addr),
    .outData    (out_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A write lands in the dump only if its register has not been captured yet (dump walks upward).
  task automatic rf_write(input int a, input logic [W-1:0] v, input int cur);
    if (a == 0) return;
    rf[a] = v;
    if (a > cur) snap[a] = v;
  endtask

  // rmode: 0 ready high, 1 random ready, 2 five-cycle stall on addr 2
  // wmode: 0 none, 1 reg20/reg3 write during beat 5, 2 random writes
  task automatic do_dump(input int rmode, input int wmode, input bit restart, input int rst_beat);
    int k = -1, stalls = 0, nacc = 0, exp_a = FIRST, bp_left = 5, w;
    bit fin = 0, prev_stall = 0, restarted = 0, wrote = 0;
    logic [A-1:0] pa;
    logic [W-1:0] pd;
    snap = rf;
    @(negedge clk);
    start = 1'b1;
    out_ready = (rmode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
    while (!fin) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (k > 8 * NREG + 200) begin
        chk("timeout", 64'(k), 64'(0));
        return;
      end
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_addr", 64'(out_addr), 64'(pa));
        chk("hold_data", 64'(out_data), 64'(pd));
      end
      if (done) begin
        chk("done_edge", 64'(k), 64'(2 * NB + stalls));
        chk("beat_count", 64'(nacc), 64'(NB));
        chk("busy_at_done", 64'(busy), 64'(0));
        fin = 1;
      end else begin
        chk("busy", 64'(busy), 64'(1));
        case (rmode)
          0: out_ready = 1'b1;
          1: out_ready = ($urandom_range(0, 3) != 0);
          default: begin
            if (out_valid && out_addr == 2 && bp_left > 0) begin
              out_ready = 1'b0;
              bp_left--;
            end else out_ready = 1'b1;
          end
        endcase
        prev_stall = out_valid && !out_ready;
        pa = out_addr;
        pd = out_data;
        if (prev_stall) stalls++;
        if (out_valid && out_ready) begin
          chk("beat_addr", 64'(out_addr), 64'(exp_a));
          chk("beat_data", 64'(out_data), 64'(snap[exp_a % NREG]));
          exp_a++;
          nacc++;
        end
        if (out_valid) begin
          if (wmode == 1 && out_addr == 5 && !wrote) begin
            rf_write(20, 32'hDEADBEEF, 5);
            rf_write(3, 32'h33333333, 5);
            wrote = 1;
          end
          if (wmode == 2 && $urandom_range(0, 3) == 0) begin
            w = $urandom_range(1, NREG - 1);
            if (w != int'(out_addr)) rf_write(w, $urandom, int'(out_addr));
          end
          if (restart && out_addr == 10 && !restarted) begin
            start = 1'b1;
            restarted = 1;
          end
          if (rst_beat >= 0 && out_addr == rst_beat) begin
            #2 reset = 1'b0;
            #1;
            chk("rst_mid_valid", 64'(out_valid), 64'(0));
            chk("rst_mid_busy", 64'(busy), 64'(0));
            chk("rst_mid_data", 64'(out_data), 64'(0));
            chk("rst_mid_addr", 64'(out_addr), 64'(0));
            repeat (3) @(posedge clk);
            #3;
            chk("rst_mid_done", 64'(done), 64'(0));
            reset = 1'b1;
            out_ready = 1'b1;
            return;
          end
        end
      end
    end
    repeat (4) begin
      @(negedge clk);
      chk("idle_after", 64'({done, out_valid, busy}), 64'(0));
    end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) rf[i] = '0;
    #3;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_addr", 64'(out_addr), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_rdreg", 64'(rd_reg), 64'(0));
    #14 reset = 1'b1;
    rf[1] = 32'h12345678;
    rf[2] = 32'h9ABCDEF1;
    do_dump(0, 0, 1'b0, -1);
    do_dump(2, 0, 1'b0, -1);
    do_dump(0, 1, 1'b1, -1);
    do_dump(0, 0, 1'b0, 7);
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 64'({done, out_valid, busy}), 64'(0));
    do_dump(0, 0, 1'b0, -1);
    for (int n = 0; n < 4; n++) begin
      for (int i = 1; i < NREG; i++) rf[i] = $urandom;
      do_dump(1, 2, 1'($urandom_range(0, 1)), -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
